// File: rtl/graph_pkg.sv
// ---------------------------------------------------------------------------
// graph_pkg
// Shared types and constants for the graph loader slice (edge stream ->
// adjacency bitmap + Q0.16 out-degree weights).
//   N_NODES    default node count (power of two, 2..16)
//   WIDTH_Q    default weight width (Q0.WIDTH_Q fixed point)
//   NODE_W     node index width, log2(N_NODES)
//   DEG_W      out-degree counter width, log2(N_NODES)+1 (holds N_NODES)
//   DIV_CYCLES cycles spent per node in the divide phase (one per quotient
//              bit of 2^WIDTH_Q / deg, i.e. WIDTH_Q+1)
//   ONE_Q      2^WIDTH_Q, the dividend of every weight division
// ---------------------------------------------------------------------------
package graph_pkg;

   localparam int N_NODES    = 16;
   localparam int WIDTH_Q    = 16;
   localparam int NODE_W     = $clog2(N_NODES);
   localparam int DEG_W      = $clog2(N_NODES) + 1;
   localparam int DIV_CYCLES = WIDTH_Q + 1;

   localparam logic [WIDTH_Q:0] ONE_Q = {1'b1, {WIDTH_Q{1'b0}}};

   typedef logic [NODE_W-1:0]  node_t;
   typedef logic [DEG_W-1:0]   deg_t;
   typedef logic [WIDTH_Q-1:0] weight_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DIVIDE,
      DONE
   } state_t;

endpackage

// File: rtl/graph_weight_div.sv
// ---------------------------------------------------------------------------
// graph_weight_div
// Sequential restoring divider computing 2^WIDTH / divisor, one quotient bit
// per cycle, WIDTH+1 cycles per division. The start cycle already performs
// the first quotient step, so the result is presented (valid_o=1) during the
// WIDTH+1-th cycle counted from start_i, ready to be registered at the end
// of that cycle. A zero divisor yields 0; a quotient of 2^WIDTH (divisor 1)
// is clamped to all ones.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   start_i    in   1-cycle pulse, samples divisor_i and begins a division
//   divisor_i  in   DW-bit divisor (out-degree)
//   valid_o    out  high in the final cycle of a division
//   result_o   out  WIDTH-bit clamped quotient, meaningful while valid_o
// ---------------------------------------------------------------------------
module graph_weight_div #(
   parameter int WIDTH = 16,
   parameter int DW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [DW-1:0]    divisor_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [DW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    div_q, div_d;
   logic             busy_q, busy_d;

   logic             active;
   logic [DW-1:0]    rem_in;
   logic [WIDTH-1:0] quo_in;
   logic [CW-1:0]    cnt_in;
   logic [DW-1:0]    dvs;
   logic [DW:0]      trial;
   logic             ge;
   logic [WIDTH:0]   quo_next;
   logic             last;

   // A start cycle computes from fresh operands rather than stale registers,
   // which is what lets a division fit in exactly WIDTH+1 cycles.
   always_comb begin
      active   = start_i | busy_q;
      rem_in   = start_i ? '0 : rem_q;
      quo_in   = start_i ? '0 : quo_q;
      cnt_in   = start_i ? '0 : cnt_q;
      dvs      = start_i ? divisor_i : div_q;
      // The dividend 2^WIDTH has only its MSB set, so the bit shifted into
      // the partial remainder is 1 on the first step and 0 afterwards.
      trial    = {rem_in, (cnt_in == '0)};
      ge       = (trial >= {1'b0, dvs});
      quo_next = {quo_in, ge};
      last     = active && (cnt_in == CW'(WIDTH));

      rem_d  = rem_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      busy_d = busy_q;
      if (active) begin
         // Remainder stays below the divisor (<= 2^(DW-1)), so DW bits hold it.
         rem_d  = ge ? DW'(trial - {1'b0, dvs}) : DW'(trial);
         // The bit dropped here is only nonzero on the final step, which is
         // consumed combinationally through quo_next and never stored.
         quo_d  = quo_next[WIDTH-1:0];
         cnt_d  = cnt_in + CW'(1);
         div_d  = dvs;
         busy_d = ~last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         div_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         busy_q <= busy_d;
      end
   end

   assign valid_o  = last;
   assign result_o = (dvs == '0)       ? '0 :
                     quo_next[WIDTH]   ? '1 :
                                         quo_next[WIDTH-1:0];

endmodule

// File: rtl/graph_loader.sv
// ---------------------------------------------------------------------------
// graph_loader
// Producer side of the pageRank16 graph interface. Accepts a serial edge
// stream (src->dst), builds the flattened N*N adjacency bitmap (row = dst,
// column = src) and per-source weights floor(2^WIDTH / outdeg), then holds
// them and raises done.
// Optional build macro:
//   SELF_LOOP_DROP_EN  defined: src==dst edges are accepted but discarded.
//                      undefined: self-loops count like any other edge.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high
//   start       in   1-cycle pulse in IDLE/DONE: clear graph, begin load
//   edge_valid  in   edge beat valid
//   edge_ready  out  high throughout LOAD (no backpressure)
//   edge_src    in   source node of edge
//   edge_dst    in   destination node of edge
//   edge_last   in   final edge of the graph
//   adjacency   out  bit [dst*N+src] set once edge src->dst loaded
//   weights     out  weights[src*WIDTH +: WIDTH] = clamped 2^WIDTH/outdeg
//   busy        out  high in LOAD or DIVIDE
//   done        out  high in DONE until next start or reset
// ---------------------------------------------------------------------------
module graph_loader
   import graph_pkg::*;
#(
   parameter int N     = N_NODES,
   parameter int WIDTH = WIDTH_Q
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 edge_valid,
   output logic                 edge_ready,
   input  logic [$clog2(N)-1:0] edge_src,
   input  logic [$clog2(N)-1:0] edge_dst,
   input  logic                 edge_last,
   output logic [N*N-1:0]       adjacency,
   output logic [N*WIDTH-1:0]   weights,
   output logic                 busy,
   output logic                 done
);

   localparam int NB = $clog2(N);
   localparam int DW = $clog2(N) + 1;
   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [N*N-1:0]   adj_q, adj_d;
   logic [DW-1:0]    deg_q [N];
   logic [DW-1:0]    deg_d [N];
   logic [WIDTH-1:0] w_q [N];
   logic [WIDTH-1:0] w_d [N];
   logic [NB-1:0]    node_q, node_d;
   logic [CW-1:0]    cyc_q, cyc_d;

   logic             div_start;
   logic             div_valid;
   logic [WIDTH-1:0] div_result;
   logic [2*NB-1:0]  bit_idx;
   logic             drop;

   // N is a power of two, so {dst, src} is exactly dst*N+src.
   assign bit_idx = {edge_dst, edge_src};

`ifdef SELF_LOOP_DROP_EN
   assign drop = (edge_src == edge_dst);
`else
   assign drop = 1'b0;
`endif

   // NOTE: every variable gets its hold value before the case statement, so
   // no path leaves one unassigned and no latch is inferred.
   // NOTE: combinational blocks use blocking '=' so later statements see the
   // updated value (e.g. a cleared array before an element write).
   always_comb begin
      state_d   = state_q;
      adj_d     = adj_q;
      deg_d     = deg_q;
      w_d       = w_q;
      node_d    = node_q;
      cyc_d     = cyc_q;
      div_start = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               adj_d   = '0;
               for (int i = 0; i < N; i++) begin
                  deg_d[i] = '0;
                  w_d[i]   = '0;
               end
            end
         end

         LOAD: begin
            if (edge_valid) begin
               // A bit already set means a duplicate edge: degree unchanged.
               if (!drop && !adj_q[bit_idx]) begin
                  adj_d[bit_idx]  = 1'b1;
                  deg_d[edge_src] = deg_q[edge_src] + DW'(1);
               end
               if (edge_last) begin
                  state_d = DIVIDE;
                  node_d  = '0;
                  cyc_d   = '0;
               end
            end
         end

         DIVIDE: begin
            // One node per WIDTH+1 cycles; the divider is launched on the
            // node's first cycle and reports on its last.
            div_start = (cyc_q == '0);
            if (div_valid) begin
               w_d[node_q] = div_result;
            end
            if (cyc_q == CW'(WIDTH)) begin
               cyc_d = '0;
               if (node_q == NB'(N - 1)) begin
                  state_d = DONE;
               end else begin
                  node_d = node_q + NB'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: the degree and weight arrays sit in flops with a full async reset;
   // reset must return every output to zero immediately, so they cannot be
   // mapped to an unreset RAM.
   // NOTE: sequential blocks use non-blocking '<=' so all registers update
   // together from values sampled at the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         adj_q   <= '0;
         node_q  <= '0;
         cyc_q   <= '0;
         for (int i = 0; i < N; i++) begin
            deg_q[i] <= '0;
            w_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         adj_q   <= adj_d;
         node_q  <= node_d;
         cyc_q   <= cyc_d;
         for (int i = 0; i < N; i++) begin
            deg_q[i] <= deg_d[i];
            w_q[i]   <= w_d[i];
         end
      end
   end

   graph_weight_div #(
      .WIDTH (WIDTH),
      .DW    (DW)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .start_i   (div_start),
      .divisor_i (deg_q[node_q]),
      .valid_o   (div_valid),
      .result_o  (div_result)
   );

   assign adjacency  = adj_q;
   assign edge_ready = (state_q == LOAD);
   assign busy       = (state_q == LOAD) || (state_q == DIVIDE);
   assign done       = (state_q == DONE);

   for (genvar g = 0; g < N; g++) begin : g_weights
      assign weights[g*WIDTH +: WIDTH] = w_q[g];
   end

endmodule

// File: tb/tb_graph_loader.sv
// ---------------------------------------------------------------------------
// tb_graph_loader
// Self-checking bench for graph_loader (N=16, WIDTH=16). A reference model
// derives the expected bitmap and weights from the set of distinct edges
// (out-degree = number of distinct destinations per source). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_graph_loader;
   import graph_pkg::*;

   localparam int N    = 16;
   localparam int W    = 16;
   localparam int CHKW = N * N;

`ifdef SELF_LOOP_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           edge_valid;
   logic           edge_ready;
   logic [3:0]     edge_src;
   logic [3:0]     edge_dst;
   logic           edge_last;
   logic [N*N-1:0] adjacency;
   logic [N*W-1:0] weights;
   logic           busy;
   logic           done;

   int n_total = 0;
   int n_bad   = 0;

   int             q_src[$];
   int             q_dst[$];
   logic [N*N-1:0] exp_adj;
   logic [W-1:0]   exp_w [N];

   graph_loader #(.N(N), .WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .edge_valid (edge_valid),
      .edge_ready (edge_ready),
      .edge_src   (edge_src),
      .edge_dst   (edge_dst),
      .edge_last  (edge_last),
      .adjacency  (adjacency),
      .weights    (weights),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [CHKW-1:0] got,
                        input logic [CHKW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected graph from the edge list: a bit per distinct edge, and the
   // weight of a source is 2^16 divided by its number of distinct targets.
   task automatic build_model();
      int deg;
      int q;
      exp_adj = '0;
      for (int i = 0; i < q_src.size(); i++) begin
         if (!(DROP && q_src[i] == q_dst[i])) exp_adj[q_dst[i]*N + q_src[i]] = 1'b1;
      end
      for (int s = 0; s < N; s++) begin
         deg = 0;
         for (int d = 0; d < N; d++) deg += int'(exp_adj[d*N + s]);
         if (deg == 0) begin
            exp_w[s] = '0;
         end else begin
            q = 65536 / deg;
            exp_w[s] = (q > 65535) ? 16'hFFFF : W'(q);
         end
      end
   endtask

   function automatic logic [W-1:0] w_of(input int node);
      return weights[node*W +: W];
   endfunction

   task automatic run_graph(input string name, input int gap_max,
                            input bit start_in_load, input bit start_in_div);
      int k;
      int g;
      int n;
      n = q_src.size();
      build_model();

      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check({name, ":clr_adj"}, adjacency, '0);
      check({name, ":clr_w"},   CHKW'(weights), '0);
      check({name, ":ready"},   CHKW'(edge_ready), CHKW'(1'b1));
      check({name, ":done_lo"}, CHKW'(done), '0);

      for (int i = 0; i < n; i++) begin
         if (start_in_load && i == 1) begin
            edge_valid = 1'b0;
            start      = 1'b1;
            @(posedge clk); #1;
            start      = 1'b0;
         end
         if (gap_max > 0) begin
            g = $urandom_range(0, gap_max);
            edge_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
         edge_valid = 1'b1;
         edge_src   = 4'(q_src[i]);
         edge_dst   = 4'(q_dst[i]);
         edge_last  = (i == n - 1);
         @(posedge clk); #1;
      end
      edge_valid = 1'b0;
      edge_last  = 1'b0;

      check({name, ":ready_div"}, CHKW'(edge_ready), '0);
      check({name, ":busy_div"},  CHKW'(busy), CHKW'(1'b1));

      k = 0;
      while (!done && k < 3000) begin
         start = start_in_div && (k == 50);
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;

      // done is first seen 16*17+1 cycles after the last-edge accept cycle,
      // i.e. N*DIV_CYCLES rising edges after the accepting edge.
      check({name, ":done_lat"}, CHKW'(k), CHKW'(N * DIV_CYCLES));
      check({name, ":adj"}, adjacency, exp_adj);
      for (int s = 0; s < N; s++) begin
         check($sformatf("%s:w%0d", name, s), CHKW'(w_of(s)), CHKW'(exp_w[s]));
      end
      check({name, ":busy_done"}, CHKW'(busy), '0);

      repeat (3) @(posedge clk);
      #1;
      check({name, ":done_hold"}, CHKW'(done), CHKW'(1'b1));
      check({name, ":adj_hold"}, adjacency, exp_adj);
   endtask

   task automatic random_edges(input int n);
      q_src.delete();
      q_dst.delete();
      for (int i = 0; i < n; i++) begin
         q_src.push_back(int'($urandom_range(0, N - 1)));
         q_dst.push_back(int'($urandom_range(0, N - 1)));
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      edge_valid = 1'b0;
      edge_src   = '0;
      edge_dst   = '0;
      edge_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst:adj",   adjacency, '0);
      check("rst:w",     CHKW'(weights), '0);
      check("rst:ready", CHKW'(edge_ready), '0);
      check("rst:busy",  CHKW'(busy), '0);
      check("rst:done",  CHKW'(done), '0);
      reset = 1'b0;

      // Small hand graph.
      q_src = '{0, 0, 3};
      q_dst = '{1, 2, 0};
      run_graph("g2", 0, 1'b0, 1'b0);
      check("g2:bit16", CHKW'(adjacency[16]), CHKW'(1'b1));
      check("g2:bit32", CHKW'(adjacency[32]), CHKW'(1'b1));
      check("g2:bit3",  CHKW'(adjacency[3]),  CHKW'(1'b1));
      check("g2:w0",    CHKW'(w_of(0)), CHKW'(16'h8000));
      check("g2:w3",    CHKW'(w_of(3)), CHKW'(16'hFFFF));
      check("g2:w1",    CHKW'(w_of(1)), '0);

      // Degree three, and a triply repeated edge counted once.
      q_src = '{7, 7, 7, 0, 0, 0};
      q_dst = '{1, 2, 3, 1, 1, 1};
      run_graph("g3", 0, 1'b0, 1'b0);
      check("g3:w7", CHKW'(w_of(7)), CHKW'(16'h5555));
      check("g3:w0", CHKW'(w_of(0)), CHKW'(16'hFFFF));

      // Node 5 fans out to every node, itself included.
      q_src.delete();
      q_dst.delete();
      for (int d = 0; d < N; d++) begin
         q_src.push_back(5);
         q_dst.push_back(d);
      end
      run_graph("g4", 0, 1'b0, 1'b0);
      check("g4:bit85", CHKW'(adjacency[85]), CHKW'(!DROP));
      check("g4:w5",    CHKW'(w_of(5)), DROP ? CHKW'(16'h1111) : CHKW'(16'h1000));

      // start pulses inside LOAD and DIVIDE must be ignored.
      random_edges(12);
      run_graph("g5", 0, 1'b1, 1'b1);

      // Random graphs, alternating back-to-back and gapped streams.
      for (int r = 0; r < 6; r++) begin
         random_edges(int'($urandom_range(1, 40)));
         run_graph($sformatf("rnd%0d", r), (r % 2) * 3, 1'b0, 1'b0);
      end

      // Same stream twice: back-to-back, then with idle gaps.
      random_edges(20);
      run_graph("g6a", 0, 1'b0, 1'b0);
      run_graph("g6b", 4, 1'b0, 1'b0);

      // Reset in the middle of DIVIDE.
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      edge_valid = 1'b1; edge_src = 4'd2; edge_dst = 4'd3; edge_last = 1'b1;
      @(posedge clk); #1;
      edge_valid = 1'b0; edge_last = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("rstdiv:busy_pre", CHKW'(busy), CHKW'(1'b1));
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstdiv:adj",   adjacency, '0);
      check("rstdiv:w",     CHKW'(weights), '0);
      check("rstdiv:done",  CHKW'(done), '0);
      check("rstdiv:busy",  CHKW'(busy), '0);
      check("rstdiv:ready", CHKW'(edge_ready), '0);
      reset = 1'b0;

      random_edges(10);
      run_graph("after_rst", 2, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
